axis_pkt_arb: RTL and testbench

AXIS_PKT_ARB -- requirements
Module: axis_pkt_arb

---
 rtl/axis_pkt_arb.sv | 134 +++++++++++++
 tb/tb_axis_pkt_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arb.sv
// Round-robin packet arbiter: merges S_COUNT AXI-Stream inputs into one registered
// output stream, holding each grant from the first beat until the owner's tlast is taken.
module axis_pkt_arb #(
    parameter int unsigned S_COUNT    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          grant_valid,
    output logic [$clog2(S_COUNT)-1:0]    grant_idx
);
    localparam int unsigned IDX_W = $clog2(S_COUNT);

    typedef enum logic {ST_IDLE, ST_PASS} state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_grant_idx;
    logic [IDX_W-1:0]      r_last_grant;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [KEEP_WIDTH-1:0] r_m_tkeep;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [USER_WIDTH-1:0] r_m_tuser;

    logic                  w_out_en;
    logic                  w_in_fire;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [KEEP_WIDTH-1:0] w_sel_keep;
    logic [USER_WIDTH-1:0] w_sel_user;
    logic [S_COUNT-1:0]    w_rot;
    logic                  w_arb_found;
    logic [IDX_W-1:0]      w_arb_idx;

    assign w_out_en  = !r_m_tvalid || m_axis_tready;
    assign w_in_fire = (r_state == ST_PASS) && w_sel_valid && w_out_en;

    // Owner input mux and per-port ready
    always_comb begin
        w_sel_valid   = 1'b0;
        w_sel_last    = 1'b0;
        w_sel_data    = '0;
        w_sel_keep    = '0;
        w_sel_user    = '0;
        s_axis_tready = '0;
        for (int unsigned i = 0; i < S_COUNT; i++) begin
            if (r_grant_idx == IDX_W'(i)) begin
                w_sel_valid      = s_axis_tvalid[i];
                w_sel_last       = s_axis_tlast[i];
                w_sel_data       = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_keep       = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                w_sel_user       = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                s_axis_tready[i] = (r_state == ST_PASS) && w_out_en;
            end
        end
    end

    // Rotate requests so bit 0 is the port just after the last grant, then take the lowest set bit
    always_comb begin
        w_rot       = S_COUNT'({s_axis_tvalid, s_axis_tvalid} >> (32'(r_last_grant) + 32'd1));
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int unsigned k = 0; k < S_COUNT; k++) begin
            if (!w_arb_found && w_rot[k]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = IDX_W'((32'(r_last_grant) + 32'd1 + k) % S_COUNT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(S_COUNT - 1);
            r_m_tdata    <= '0;
            r_m_tkeep    <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_tuser    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_found) begin
                        r_grant_idx <= w_arb_idx;
                        r_state     <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_in_fire && w_sel_last) begin
                        r_last_grant <= r_grant_idx;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Output register: load on owner handshake, drain when the sink accepts
            if (w_in_fire) begin
                r_m_tdata  <= w_sel_data;
                r_m_tkeep  <= w_sel_keep;
                r_m_tlast  <= w_sel_last;
                r_m_tuser  <= w_sel_user;
                r_m_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tuser  = r_m_tuser;
    assign grant_valid   = (r_state == ST_PASS);
    assign grant_idx     = r_grant_idx;

endmodule

// File: tb/tb_axis_pkt_arb.sv
// Directed bench for axis_pkt_arb: per-port source queues feed the DUT, a scoreboard
// holds beats in predicted output order, and per-cycle logs back timing checks.
module tb_axis_pkt_arb;
    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       l;
        logic       u;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic [3:0]  s_tvalid = '0;
    logic [3:0]  s_tready;
    logic [3:0]  s_tlast = '0;
    logic [3:0]  s_tuser = '0;
    logic [7:0]  m_tdata;
    logic        m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        m_tuser;
    logic        gvalid;
    logic [1:0]  gidx;

    axis_pkt_arb #(.S_COUNT(4), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .grant_valid(gvalid), .grant_idx(gidx)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    seq = 0;
    int    extra = 0;
    int    bp_from = 1000;
    int    bp_to = 0;
    int    gap_port = -1;
    int    gap_from = 1000;
    int    gap_to = 0;
    logic [3:0] fired = '0;
    beat_t src_q [4][$];
    beat_t sb [$];
    int    out_cyc [$];
    int    exp_q [$];
    logic       gv_log [64];
    logic [1:0] gi_log [64];
    logic       mv_log [64];
    logic [7:0] md_log [64];
    logic [3:0] tr_log [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one packet on a port and push its beats to the scoreboard in call order
    task automatic add_pkt(input int port, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = 8'(port * 64 + seq);
            b.k = 1'((seq >> 1) & 1);
            b.u = 1'(seq & 1);
            b.l = (i == n - 1);
            seq++;
            src_q[port].push_back(b);
            sb.push_back(b);
        end
    endtask

    task automatic drive();
        beat_t b;
        m_tready = !(cyc >= bp_from && cyc < bp_to);
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0 && !(i == gap_port && cyc >= gap_from && cyc < gap_to)) begin
                b = src_q[i][0];
                s_tvalid[i] = 1'b1;
                s_tdata[i*8 +: 8] = b.d;
                s_tkeep[i] = b.k;
                s_tlast[i] = b.l;
                s_tuser[i] = b.u;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i*8 +: 8] = 8'h00;
                s_tkeep[i] = 1'b0;
                s_tlast[i] = 1'b0;
                s_tuser[i] = 1'b0;
            end
        end
    endtask

    task automatic sample();
        beat_t e;
        @(negedge clk);
        fired = s_tvalid & s_tready;
        if (cyc < 64) begin
            gv_log[cyc] = gvalid;
            gi_log[cyc] = gidx;
            mv_log[cyc] = m_tvalid;
            md_log[cyc] = m_tdata;
            tr_log[cyc] = s_tready;
        end
        if (m_tvalid && m_tready) begin
            out_cyc.push_back(cyc);
            if (sb.size() == 0) extra++;
            else begin
                e = sb.pop_front();
                chk("beat", 32'({m_tdata, m_tkeep, m_tlast, m_tuser}), 32'(e));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 4; i++)
            if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            sample();
            advance();
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        sb.delete();
        out_cyc.delete();
        exp_q.delete();
        fired = '0;
        s_tvalid = '0;
        m_tready = 1'b1;
        bp_from = 1000; bp_to = 0;
        gap_port = -1; gap_from = 1000; gap_to = 0;
        seq = 0;
        extra = 0;
        for (int i = 0; i < 64; i++) begin
            gv_log[i] = 1'b0; gi_log[i] = 2'd0; mv_log[i] = 1'b0;
            md_log[i] = 8'h00; tr_log[i] = 4'h0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycle 0 is the first cycle with the queued tvalids driven
    task automatic start();
        @(posedge clk);
        #1;
        cyc = 0;
        fired = '0;
        drive();
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_extra"}, 32'(extra), 32'd0);
        chk({tag, "_nbeats"}, 32'(out_cyc.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_cyc.size(); i++)
            chk({tag, "_out_cyc"}, 32'(out_cyc[i]), 32'(exp_q[i]));
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_gvalid", 32'(gvalid), 32'd0);
        chk("rst_gidx", 32'(gidx), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_mfields", 32'({m_tdata, m_tkeep, m_tlast, m_tuser}), 32'd0);

        // Single port: 3-beat packet on port 2
        do_reset();
        add_pkt(2, 3);
        for (int i = 0; i < 3; i++) exp_q.push_back(2 + i);
        start();
        run(8);
        chk("t1_gv0", 32'(gv_log[0]), 32'd0);
        chk("t1_gv1", 32'(gv_log[1]), 32'd1);
        chk("t1_gi1", 32'(gi_log[1]), 32'd2);
        chk("t1_tready1", 32'(tr_log[1]), 32'h4);
        end_checks("t1");

        // Contention: ports 0,1,3 with 2-beat packets, then port 0 again
        do_reset();
        add_pkt(0, 2); add_pkt(1, 2); add_pkt(3, 2); add_pkt(0, 2);
        for (int i = 0; i < 8; i++) exp_q.push_back(2 + 3 * (i / 2) + (i % 2));
        start();
        run(16);
        chk("t2_gi_p0", 32'(gi_log[1]), 32'd0);
        chk("t2_bubble", 32'(gv_log[3]), 32'd0);
        chk("t2_gi_p1", 32'(gi_log[4]), 32'd1);
        chk("t2_gi_p3", 32'(gi_log[7]), 32'd3);
        chk("t2_gi_p0b", 32'(gi_log[10]), 32'd0);
        end_checks("t2");

        // Backpressure: sink stalls cycles 3..7 while beat 1 is held
        do_reset();
        add_pkt(1, 4);
        bp_from = 3; bp_to = 8;
        exp_q.push_back(2); exp_q.push_back(8); exp_q.push_back(9); exp_q.push_back(10);
        start();
        run(14);
        for (int c = 3; c < 8; c++) begin
            chk("t3_hold_valid", 32'(mv_log[c]), 32'd1);
            chk("t3_hold_data", 32'(md_log[c]), 32'h41);
            chk("t3_owner_rdy", 32'(tr_log[c]), 32'd0);
        end
        end_checks("t3");

        // Owner gap: port 0 idles 3 cycles mid-packet while port 1 waits
        do_reset();
        add_pkt(0, 4); add_pkt(1, 2);
        gap_port = 0; gap_from = 3; gap_to = 6;
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(7);
        exp_q.push_back(8); exp_q.push_back(10); exp_q.push_back(11);
        start();
        run(15);
        for (int c = 3; c < 6; c++) begin
            chk("t4_gap_gv", 32'(gv_log[c]), 32'd1);
            chk("t4_gap_gi", 32'(gi_log[c]), 32'd0);
            chk("t4_gap_rdy1", 32'(tr_log[c][1]), 32'd0);
        end
        chk("t4_bubble", 32'(gv_log[8]), 32'd0);
        chk("t4_gi_p1", 32'(gi_log[9]), 32'd1);
        end_checks("t4");

        // Reset during the 2nd beat of a 4-beat packet on port 2
        do_reset();
        add_pkt(2, 4);
        start();
        run(2);
        sample();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("t5_rst_gvalid", 32'(gvalid), 32'd0);
        chk("t5_rst_tready", 32'(s_tready), 32'd0);
        chk("t5_first_beat", 32'(out_cyc.size()), 32'd1);
        flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        add_pkt(0, 1); add_pkt(2, 1);
        exp_q.push_back(2); exp_q.push_back(4);
        start();
        run(8);
        chk("t5_gi_first", 32'(gi_log[1]), 32'd0);
        chk("t5_gi_second", 32'(gi_log[3]), 32'd2);
        end_checks("t5");

        // Back-to-back single-beat packets from all ports
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < 4; p++) add_pkt(p, 1);
        for (int i = 0; i < 12; i++) exp_q.push_back(2 + 2 * i);
        start();
        run(30);
        for (int i = 0; i < 12; i++)
            chk("t6_rr_gi", 32'(gi_log[1 + 2 * i]), 32'(i % 4));
        end_checks("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
